// File: rtl/jtcop_mcu_mbox_pkg.sv
// Shared sizing helpers and the strobe event bundle
// used by the 68000/i8751 mailbox.
package jtcop_mcu_mbox_pkg;

  typedef struct packed {
    logic mwr;
    logic mrd;
    logic crd;
    logic cwr;
  } mbox_ev_t;

  function automatic int cw_of(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int lb_of(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/jtcop_mcu_mbox_ch.sv
// One mailbox channel: main->MCU word, MCU->main word,
// optional staging word and the two "new data" flags.
module jtcop_mcu_mbox_ch
  import jtcop_mcu_mbox_pkg::*;
#(
  parameter int DW = 16,
  parameter bit ATOMIC = 1'b0,
  localparam int LANES = DW / 8,
  localparam int LB = lb_of(DW)
) (
  input  logic             clk,
  input  logic             rstn,
  input  mbox_ev_t         ev_i,
  input  logic             msel_i,
  input  logic             csel_i,
  input  logic [LANES-1:0] dsn_i,
  input  logic [DW-1:0]    din_i,
  input  logic [LB-1:0]    lane_i,
  input  logic [7:0]       byte_i,
  output logic [DW-1:0]    rx_o,
  output logic [DW-1:0]    tx_o,
  output logic             main_new_o,
  output logic             mcu_new_o
);

  localparam logic [LB-1:0] TOP = LB'(LANES - 1);

  logic [DW-1:0] rx_q, rx_d;
  logic [DW-1:0] tx_q, tx_d;
  logic [DW-1:0] stg_q, stg_d;
  logic          mnew_q, mnew_d;
  logic          cnew_q, cnew_d;
  logic          wr, top;

  assign wr  = ev_i.cwr & csel_i;
  assign top = (lane_i == TOP);

  // clears first so a coincident set wins
  always_comb begin
    rx_d   = rx_q;
    tx_d   = tx_q;
    stg_d  = stg_q;
    mnew_d = mnew_q;
    cnew_d = cnew_q;
    if (ev_i.crd & csel_i & top) cnew_d = 1'b0;
    if (ev_i.mrd & msel_i) mnew_d = 1'b0;
    if (ev_i.mwr & msel_i) begin
      for (int i = 0; i < LANES; i++)
        if (!dsn_i[i]) rx_d[8*i +: 8] = din_i[8*i +: 8];
      cnew_d = 1'b1;
    end
    if (wr) begin
      if (ATOMIC) begin
        stg_d[{lane_i, 3'b000} +: 8] = byte_i;
        if (top) tx_d = stg_d;
      end else begin
        tx_d[{lane_i, 3'b000} +: 8] = byte_i;
      end
      if (top) mnew_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_q   <= '0;
      tx_q   <= '0;
      stg_q  <= '0;
      mnew_q <= 1'b0;
      cnew_q <= 1'b0;
    end else begin
      rx_q   <= rx_d;
      tx_q   <= tx_d;
      stg_q  <= stg_d;
      mnew_q <= mnew_d;
      cnew_q <= cnew_d;
    end
  end

  assign rx_o       = rx_q;
  assign tx_o       = tx_q;
  assign main_new_o = mnew_q;
  assign mcu_new_o  = cnew_q;

endmodule

// File: rtl/jtcop_mcu_mbox.sv
// Mailbox between the 68000 main bus and the i8751 MCU:
// shared strobe edge detect, MCU read byte and INT1 request.
module jtcop_mcu_mbox
  import jtcop_mcu_mbox_pkg::*;
#(
  parameter int DW = 16,
  parameter int NCH = 1,
  parameter bit ATOMIC = 1'b0,
  parameter logic [NCH-1:0] IRQMSK = NCH'(1),
  localparam int LANES = DW / 8,
  localparam int CW = cw_of(NCH),
  localparam int LB = lb_of(DW)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             main_cs,
  input  logic             main_rnw,
  input  logic [LANES-1:0] main_dsn,
  input  logic [CW-1:0]    main_ch,
  input  logic [DW-1:0]    main_din,
  output logic [DW-1:0]    main_dout,
  output logic [NCH-1:0]   main_new,
  input  logic             mcu_rd,
  input  logic             mcu_wr,
  input  logic [CW+LB-1:0] mcu_idx,
  input  logic [7:0]       mcu_dout,
  output logic [7:0]       mcu_din,
  input  logic             mcu_irq_clrn,
  output logic             mcu_intn,
  output logic [NCH-1:0]   mcu_new
);

  logic          cs_q, rd_q, wr_q;
  logic          intn_q, intn_d;
  logic [7:0]    din_q, din_d;
  logic [7:0]    rxb;
  logic          irq_req;
  logic [CW-1:0] cch;
  logic [LB-1:0] lane;
  mbox_ev_t      ev;
  logic [DW-1:0] rx [NCH];
  logic [DW-1:0] tx [NCH];

  assign cch  = mcu_idx[CW+LB-1:LB];
  assign lane = mcu_idx[LB-1:0];

  // a write with every lane disabled is not an event
  assign ev.mwr = main_cs & ~cs_q & ~main_rnw & ~&main_dsn;
  assign ev.mrd = main_cs & ~cs_q & main_rnw;
  assign ev.crd = mcu_rd & ~rd_q;
  assign ev.cwr = mcu_wr & ~wr_q;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    jtcop_mcu_mbox_ch #(
      .DW     (DW),
      .ATOMIC (ATOMIC)
    ) u_ch (
      .clk        (clk),
      .rstn       (rstn),
      .ev_i       (ev),
      .msel_i     (main_ch == CW'(c)),
      .csel_i     (cch == CW'(c)),
      .dsn_i      (main_dsn),
      .din_i      (main_din),
      .lane_i     (lane),
      .byte_i     (mcu_dout),
      .rx_o       (rx[c]),
      .tx_o       (tx[c]),
      .main_new_o (main_new[c]),
      .mcu_new_o  (mcu_new[c])
    );
  end

  // unmatched channel indices fall through to zero
  always_comb begin
    main_dout = '0;
    rxb       = '0;
    irq_req   = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (main_ch == CW'(c)) begin
        main_dout = tx[c];
        irq_req   = ev.mwr & IRQMSK[c];
      end
      if (cch == CW'(c)) rxb = rx[c][{lane, 3'b000} +: 8];
    end
  end

  always_comb begin
    din_d  = din_q;
    intn_d = intn_q;
    if (ev.crd) din_d = rxb;
    if (!mcu_irq_clrn) intn_d = 1'b1;
    else if (irq_req) intn_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cs_q   <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      din_q  <= '0;
      intn_q <= 1'b1;
    end else begin
      cs_q   <= main_cs;
      rd_q   <= mcu_rd;
      wr_q   <= mcu_wr;
      din_q  <= din_d;
      intn_q <= intn_d;
    end
  end

  assign mcu_din  = din_q;
  assign mcu_intn = intn_q;

endmodule

// File: tb/tb_jtcop_mcu_mbox.sv
// Scoreboard bench for two mailbox builds:
// dut0 = 16-bit/1ch/direct, dut1 = 32-bit/3ch/atomic.
`timescale 1ns/1ps
module tb_jtcop_mcu_mbox;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        a_cs, a_rnw, a_rd, a_wr, a_clrn, a_intn;
  logic [1:0]  a_dsn, a_idx;
  logic [0:0]  a_ch, a_mnew, a_cnew;
  logic [15:0] a_din, a_dout;
  logic [7:0]  a_mdo, a_mdi;

  logic        b_cs, b_rnw, b_rd, b_wr, b_clrn, b_intn;
  logic [3:0]  b_dsn, b_idx;
  logic [1:0]  b_ch;
  logic [2:0]  b_mnew, b_cnew;
  logic [31:0] b_din, b_dout;
  logic [7:0]  b_mdo, b_mdi;

  jtcop_mcu_mbox #(
    .DW(16), .NCH(1), .ATOMIC(1'b0), .IRQMSK(1'b1)
  ) u_a (
    .clk(clk), .rstn(rstn),
    .main_cs(a_cs), .main_rnw(a_rnw), .main_dsn(a_dsn),
    .main_ch(a_ch), .main_din(a_din), .main_dout(a_dout),
    .main_new(a_mnew), .mcu_rd(a_rd), .mcu_wr(a_wr),
    .mcu_idx(a_idx), .mcu_dout(a_mdo), .mcu_din(a_mdi),
    .mcu_irq_clrn(a_clrn), .mcu_intn(a_intn), .mcu_new(a_cnew)
  );

  jtcop_mcu_mbox #(
    .DW(32), .NCH(3), .ATOMIC(1'b1), .IRQMSK(3'b101)
  ) u_b (
    .clk(clk), .rstn(rstn),
    .main_cs(b_cs), .main_rnw(b_rnw), .main_dsn(b_dsn),
    .main_ch(b_ch), .main_din(b_din), .main_dout(b_dout),
    .main_new(b_mnew), .mcu_rd(b_rd), .mcu_wr(b_wr),
    .mcu_idx(b_idx), .mcu_dout(b_mdo), .mcu_din(b_mdi),
    .mcu_irq_clrn(b_clrn), .mcu_intn(b_intn), .mcu_new(b_cnew)
  );

  typedef struct {
    bit cs, rnw, rd, wr, clrn;
    bit [3:0] dsn;
    int ch, mch, lane;
    bit [31:0] din;
    bit [7:0] mdo;
  } stim_t;

  typedef struct {
    int d;
    bit [31:0] dout;
    bit [3:0] mnew, cnew;
    bit [7:0] din;
    bit intn;
  } exp_t;

  exp_t q[$];
  int ntest = 0;
  int nfail = 0;

  // reference model: byte arrays per build/channel/lane
  bit [7:0] rx [2][4][4];
  bit [7:0] tx [2][4][4];
  bit [7:0] stg [2][4][4];
  bit mnew [2][4];
  bit cnew [2][4];
  bit intn [2];
  bit [7:0] dinm [2];
  bit pcs [2], prd [2], pwr [2];

  function automatic int nl(int d); return d ? 4 : 2; endfunction
  function automatic int nc(int d); return d ? 3 : 1; endfunction
  function automatic bit atom(int d); return d != 0; endfunction
  function automatic bit msk(int d, int c);
    if (d == 0) return c == 0;
    return (c == 0) || (c == 2);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    ntest++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        for (int l = 0; l < 4; l++) begin
          rx[d][c][l] = 0; tx[d][c][l] = 0; stg[d][c][l] = 0;
        end
        mnew[d][c] = 0; cnew[d][c] = 0;
      end
      intn[d] = 1; dinm[d] = 0;
      pcs[d] = 0; prd[d] = 0; pwr[d] = 0;
    end
  endtask

  task automatic step(int d, stim_t s);
    bit mev, rev, wev, req, any;
    int top;
    exp_t e;
    top = nl(d) - 1;
    mev = s.cs && !pcs[d];
    rev = s.rd && !prd[d];
    wev = s.wr && !pwr[d];
    pcs[d] = s.cs; prd[d] = s.rd; pwr[d] = s.wr;
    req = 0;
    any = 0;
    for (int i = 0; i < nl(d); i++) if (!s.dsn[i]) any = 1;
    // MCU read observes the word as it was before this edge
    if (rev) dinm[d] = (s.mch < nc(d)) ? rx[d][s.mch][s.lane] : 8'h00;
    if (rev && s.mch < nc(d) && s.lane == top) cnew[d][s.mch] = 0;
    if (mev && s.rnw && s.ch < nc(d)) mnew[d][s.ch] = 0;
    if (mev && !s.rnw && s.ch < nc(d) && any) begin
      for (int i = 0; i < nl(d); i++)
        if (!s.dsn[i]) rx[d][s.ch][i] = s.din[8*i +: 8];
      cnew[d][s.ch] = 1;
      req = msk(d, s.ch);
    end
    if (wev && s.mch < nc(d)) begin
      if (atom(d)) begin
        stg[d][s.mch][s.lane] = s.mdo;
        if (s.lane == top)
          for (int i = 0; i < nl(d); i++) tx[d][s.mch][i] = stg[d][s.mch][i];
      end else begin
        tx[d][s.mch][s.lane] = s.mdo;
      end
      if (s.lane == top) mnew[d][s.mch] = 1;
    end
    if (!s.clrn) intn[d] = 1;
    else if (req) intn[d] = 0;
    e.d = d;
    e.dout = 0;
    if (s.ch < nc(d))
      for (int i = 0; i < nl(d); i++) e.dout[8*i +: 8] = tx[d][s.ch][i];
    e.mnew = 0;
    e.cnew = 0;
    for (int c = 0; c < nc(d); c++) begin
      e.mnew[c] = mnew[d][c];
      e.cnew[c] = cnew[d][c];
    end
    e.din = dinm[d];
    e.intn = intn[d];
    q.push_back(e);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.cs = 0; s.rnw = 1; s.rd = 0; s.wr = 0; s.clrn = 1;
    s.dsn = 4'hF; s.ch = 0; s.mch = 0; s.lane = 0;
    s.din = 0; s.mdo = 0;
    return s;
  endfunction

  function automatic stim_t mw(int ch, bit [3:0] dsn, bit [31:0] v);
    stim_t s = idle();
    s.cs = 1; s.rnw = 0; s.ch = ch; s.dsn = dsn; s.din = v;
    return s;
  endfunction

  function automatic stim_t mr(int ch);
    stim_t s = idle();
    s.cs = 1; s.rnw = 1; s.ch = ch;
    return s;
  endfunction

  function automatic stim_t cr(int ch, int lane);
    stim_t s = idle();
    s.rd = 1; s.mch = ch; s.lane = lane;
    return s;
  endfunction

  function automatic stim_t cw(int ch, int lane, bit [7:0] v);
    stim_t s = idle();
    s.wr = 1; s.mch = ch; s.ch = ch; s.lane = lane; s.mdo = v;
    return s;
  endfunction

  function automatic stim_t rnd(int d);
    stim_t s;
    s.cs = 1'($urandom_range(0, 1));
    s.rnw = 1'($urandom_range(0, 1));
    s.rd = 1'($urandom_range(0, 1));
    s.wr = 1'($urandom_range(0, 1));
    s.clrn = ($urandom_range(0, 7) != 0);
    s.dsn = 4'($urandom_range(0, 15));
    s.ch = $urandom_range(0, d ? 3 : 1);
    s.mch = $urandom_range(0, d ? 3 : 1);
    s.lane = $urandom_range(0, nl(d) - 1);
    s.din = $urandom;
    s.mdo = 8'($urandom);
    return s;
  endfunction

  task automatic apply(int d, stim_t s);
    if (d == 0) begin
      a_cs = s.cs; a_rnw = s.rnw; a_dsn = s.dsn[1:0];
      a_ch = s.ch[0]; a_din = s.din[15:0];
      a_rd = s.rd; a_wr = s.wr; a_mdo = s.mdo; a_clrn = s.clrn;
      a_idx = {s.mch[0], s.lane[0]};
    end else begin
      b_cs = s.cs; b_rnw = s.rnw; b_dsn = s.dsn;
      b_ch = s.ch[1:0]; b_din = s.din;
      b_rd = s.rd; b_wr = s.wr; b_mdo = s.mdo; b_clrn = s.clrn;
      b_idx = {s.mch[1:0], s.lane[1:0]};
    end
  endtask

  task automatic drive(stim_t sa, stim_t sb);
    apply(0, sa); apply(1, sb);
    step(0, sa); step(1, sb);
  endtask

  task automatic cyc(stim_t sa, stim_t sb);
    @(negedge clk);
    drive(sa, sb);
  endtask

  // one idle cycle, the op, then sample just after its edge
  task automatic pulse(stim_t sa, stim_t sb);
    cyc(idle(), idle());
    cyc(sa, sb);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst a intn", a_intn, 1);
    chk("rst a main_new", a_mnew, 0);
    chk("rst a mcu_new", a_cnew, 0);
    chk("rst a mcu_din", a_mdi, 0);
    chk("rst a main_dout", a_dout, 0);
    chk("rst b intn", b_intn, 1);
    chk("rst b main_new", b_mnew, 0);
    chk("rst b mcu_new", b_cnew, 0);
    chk("rst b mcu_din", b_mdi, 0);
    chk("rst b main_dout", b_dout, 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    drive(idle(), idle());
  endtask

  initial begin : monitor
    exp_t e;
    logic [31:0] ad;
    logic [3:0] am, ac;
    logic [7:0] ai;
    logic an;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.d == 0) begin
          ad = {16'h0, a_dout}; am = {3'b0, a_mnew};
          ac = {3'b0, a_cnew}; ai = a_mdi; an = a_intn;
        end else begin
          ad = b_dout; am = {1'b0, b_mnew};
          ac = {1'b0, b_cnew}; ai = b_mdi; an = b_intn;
        end
        chk($sformatf("dut%0d main_dout", e.d), ad, e.dout);
        chk($sformatf("dut%0d main_new", e.d), am, e.mnew);
        chk($sformatf("dut%0d mcu_new", e.d), ac, e.cnew);
        chk($sformatf("dut%0d mcu_din", e.d), ai, e.din);
        chk($sformatf("dut%0d mcu_intn", e.d), an, e.intn);
      end
    end
  end

  initial begin : stim
    stim_t s;
    stim_t n;
    apply(0, idle());
    apply(1, idle());
    model_reset();
    do_reset();
    n = idle();

    pulse(mw(0, 4'h0, 32'hA55A), n);
    chk("t2 mcu_new set", a_cnew, 1);
    chk("t2 intn req", a_intn, 0);
    pulse(cr(0, 1), n);
    chk("t2 lane1 byte", a_mdi, 8'hA5);
    chk("t2 mcu_new clr", a_cnew, 0);
    pulse(cr(0, 0), n);
    chk("t2 lane0 byte", a_mdi, 8'h5A);
    s = idle(); s.clrn = 0;
    pulse(s, n);
    chk("t2 intn ack", a_intn, 1);

    pulse(cw(0, 0, 8'h12), n);
    chk("t4 low byte", a_dout, 16'h0012);
    chk("t4 no new", a_mnew, 0);
    pulse(cw(0, 1, 8'h34), n);
    chk("t4 word", a_dout, 16'h3412);
    chk("t4 new", a_mnew, 1);

    pulse(n, cw(0, 0, 8'h11));
    pulse(n, cw(0, 1, 8'h22));
    pulse(n, cw(0, 2, 8'h33));
    chk("t3 staged hidden", b_dout, 0);
    chk("t3 staged no new", b_mnew, 0);
    pulse(n, cw(0, 3, 8'h44));
    chk("t3 commit", b_dout, 32'h44332211);
    chk("t3 new", b_mnew, 3'b001);
    pulse(n, mr(0));
    chk("t3 read clr", b_mnew, 0);

    pulse(n, mw(1, 4'h0, 32'hCAFEF00D));
    chk("mask off intn", b_intn, 1);
    chk("mask off new", b_cnew, 3'b010);
    pulse(n, mw(2, 4'b1110, 32'h0BADBEEF));
    chk("mask on intn", b_intn, 0);
    chk("mask on new", b_cnew, 3'b110);
    pulse(n, mw(3, 4'h0, 32'h12345678));
    chk("ch3 write ignored", b_cnew, 3'b110);
    pulse(n, cr(3, 0));
    chk("ch3 read zero", b_mdi, 0);

    do_reset();
    s = mw(0, 4'b0010, 32'hFFEE);
    s.clrn = 0;
    pulse(s, n);
    chk("t5 intn dropped", a_intn, 1);
    chk("t5 new", a_cnew, 1);
    pulse(cr(0, 0), n);
    chk("t5 lane0", a_mdi, 8'hEE);
    pulse(cr(0, 1), n);
    chk("t5 lane1", a_mdi, 8'h00);
    pulse(mw(1, 4'h0, 32'h1234), n);
    chk("t5 ch1 flags", a_cnew, 0);
    chk("t5 ch1 intn", a_intn, 1);
    s = mw(0, 4'h0, 32'hBEEF);
    s.rd = 1; s.mch = 0; s.lane = 1;
    pulse(s, n);
    chk("coinc pre-write", a_mdi, 8'h00);
    chk("coinc new set", a_cnew, 1);

    s = cw(0, 1, 8'h77);
    s.cs = 1; s.rnw = 1;
    pulse(s, n);
    chk("t6 set beats clr", a_mnew, 1);
    s.cs = 0;
    for (int i = 0; i < 9; i++) begin
      s.mdo = 8'($urandom);
      cyc(s, n);
    end
    @(posedge clk);
    #2;
    chk("t6 one store", {24'h0, a_dout[15:8]}, 32'h77);

    pulse(n, cw(1, 0, 8'hAA));
    pulse(n, cw(1, 1, 8'hBB));
    do_reset();
    pulse(n, cw(1, 2, 8'hCC));
    pulse(n, cw(1, 3, 8'hDD));
    chk("staging lost", b_dout, 32'hDDCC0000);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc(rnd(0), rnd(1));
    end
    cyc(idle(), idle());
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
